// File: rtl/lfsr_decrypt_engine.sv
// lfsr_decrypt_engine
//   Decrypts a space-preamble LFSR-encrypted byte stream. The first byte is
//   always an encrypted space, so the LFSR start state is recovered from it.
//   The remaining preamble bytes are dropped and payload bytes are emitted
//   through a single-entry output buffer.
//
//   Optional feature macro: LFSR_TAP_SEARCH_EN. When it is defined, the Taps
//   input is ignored. The engine picks the feedback taps from a fixed
//   candidate table by checking each candidate against the preamble.
//
// Ports
//   Clk, Reset        clock (rising edge), synchronous active-high reset
//   Start             one-cycle pulse in IDLE; latches Taps, PreLen, MsgLen
//   Taps              LFSR feedback tap mask
//   PreLen            leading space byte count (0 is treated as 1)
//   MsgLen            total encrypted bytes including the preamble
//   InValid/InReady   encrypted byte handshake, InData carries the byte
//   OutValid/OutReady plaintext byte handshake, OutData carries the byte
//   Busy              high while seeding or running
//   Done              one-cycle pulse when the message completes
//   TapErr            sticky tap-search failure (0 without the feature)
module lfsr_decrypt_engine #(
  parameter int W  = 8,
  parameter int L  = 7,
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [L-1:0]  Taps,
  input  logic [5:0]    PreLen,
  input  logic [CW-1:0] MsgLen,
  input  logic          InValid,
  output logic          InReady,
  input  logic [W-1:0]  InData,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [W-1:0]  OutData,
  output logic          Busy,
  output logic          Done,
  output logic          TapErr
);

  localparam logic [W-1:0]  SPACE = W'(32'h20);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_RUN, S_DONE} state_t;

  function automatic logic [L-1:0] lfsr_next(input logic [L-1:0] s,
                                             input logic [L-1:0] t);
    return {s[L-2:0], ^(s & t)};
  endfunction

  state_t        st, st_nxt;
  logic [5:0]    pre_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] idx;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          done_q;

  logic [L-1:0]  ks_state;    // keystream state applied to the current byte
  logic [L-1:0]  seed_state;  // start state recovered from byte 0
  logic [W-1:0]  plain;
  logic          accept;
  logic          is_pre;
  logic          last_byte;

  assign accept     = InValid && InReady;
  assign is_pre     = idx < {{(CW-6){1'b0}}, pre_q};
  assign last_byte  = (idx == len_q - ONE);
  assign seed_state = InData[L-1:0] ^ SPACE[L-1:0];
  assign plain      = InData ^ {{(W-L){1'b0}}, ks_state};

  assign OutValid = out_valid;
  assign OutData  = out_data;
  assign Done     = done_q;
  assign Busy     = (st == S_SEED) || (st == S_RUN);

  always_comb begin
    st_nxt  = st;
    InReady = 1'b0;
    case (st)
      S_IDLE: begin
        if (Start) st_nxt = (MsgLen == '0) ? S_DONE : S_SEED;
      end
      S_SEED: begin
        InReady = 1'b1;
        if (accept) st_nxt = (len_q == ONE) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        InReady = !out_valid || OutReady;
        if (accept && last_byte) st_nxt = S_DONE;
      end
      S_DONE: begin
        if (!out_valid) st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st        <= S_IDLE;
      pre_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      st     <= st_nxt;
      done_q <= (st == S_DONE) && !out_valid;
      // Drain first; a load in the same cycle below overrides the clear.
      if (out_valid && OutReady) out_valid <= 1'b0;
      case (st)
        S_IDLE: begin
          if (Start) begin
            pre_q <= (PreLen == '0) ? 6'd1 : PreLen;
            len_q <= MsgLen;
            idx   <= '0;
          end
        end
        S_SEED: begin
          if (accept) idx <= ONE;
        end
        S_RUN: begin
          if (accept) begin
            idx <= idx + ONE;
            if (!is_pre) begin
              out_data  <= plain;
              out_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LFSR_TAP_SEARCH_EN
  localparam int unsigned NC = 9;

  function automatic logic [L-1:0] cand(input int unsigned i);
    case (i)
      0:       return 7'h60;
      1:       return 7'h48;
      2:       return 7'h78;
      3:       return 7'h72;
      4:       return 7'h6A;
      5:       return 7'h69;
      6:       return 7'h5C;
      7:       return 7'h7E;
      8:       return 7'h7B;
      default: return 7'h60;
    endcase
  endfunction

  logic [L-1:0]  sh [NC];
  logic [NC-1:0] alive;
  logic          tap_err;

  // Lowest-index alive candidate wins; candidate 0 when none survive.
  always_comb begin
    ks_state = sh[0];
    for (int unsigned c = 0; c < NC; c++) begin
      if (alive[NC-1-c]) ks_state = sh[NC-1-c];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned c = 0; c < NC; c++) sh[c] <= '0;
      alive   <= '0;
      tap_err <= 1'b0;
    end else begin
      if (st == S_IDLE && Start) begin
        alive   <= '1;
        tap_err <= 1'b0;
      end
      if (st == S_SEED && accept) begin
        for (int unsigned c = 0; c < NC; c++)
          sh[c] <= lfsr_next(seed_state, cand(c));
      end
      if (st == S_RUN && accept) begin
        for (int unsigned c = 0; c < NC; c++) begin
          sh[c] <= lfsr_next(sh[c], cand(c));
          if (is_pre && ((InData ^ {{(W-L){1'b0}}, sh[c]}) != SPACE))
            alive[c] <= 1'b0;
        end
        if (!is_pre && alive == '0) tap_err <= 1'b1;
      end
    end
  end

  assign TapErr = tap_err;
`else
  logic [L-1:0] taps_q;
  logic [L-1:0] lfsr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      taps_q <= '0;
      lfsr   <= '0;
    end else begin
      if (st == S_IDLE && Start) taps_q <= Taps;
      if (st == S_SEED && accept)
        lfsr <= lfsr_next(seed_state, taps_q);
      else if (st == S_RUN && accept)
        lfsr <= lfsr_next(lfsr, taps_q);
    end
  end

  assign ks_state = lfsr;
  assign TapErr   = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
module tb_lfsr_decrypt_engine;
  logic       Clk = 1'b0;
  logic       Reset, Start;
  logic [6:0] Taps;
  logic [5:0] PreLen;
  logic [7:0] MsgLen;
  logic       InValid, InReady;
  logic [7:0] InData;
  logic       OutValid, OutReady;
  logic [7:0] OutData;
  logic       Busy, Done, TapErr;

  lfsr_decrypt_engine #(.W(8), .L(7), .CW(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Taps(Taps), .PreLen(PreLen),
    .MsgLen(MsgLen), .InValid(InValid), .InReady(InReady), .InData(InData),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .Busy(Busy), .Done(Done), .TapErr(TapErr)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;
  int done_cnt = 0, out_cnt = 0;
  int or_mode = 0;            // 0: OutReady=1, 1: OutReady=0, 2: random
  logic [7:0] expq[$];
  logic [7:0] cbuf[$];

  // Reference: the encryption program's keystream rule, as plain arithmetic.
  function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
    int v;
    v = (int'(s) * 2 + ($countones(s & t) % 2)) % 128;
    return 7'(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) begin
    #1;
    if (or_mode == 0) OutReady = 1'b1;
    else if (or_mode == 1) OutReady = 1'b0;
    else OutReady = 1'($urandom % 2);
  end

  // Monitor: pops the scoreboard on every output handshake.
  logic       stall_prev = 1'b0, rst_prev = 1'b1;
  logic [7:0] held = '0;
  always @(negedge Clk) begin
    if (Done) done_cnt++;
    if (!rst_prev && stall_prev) begin
      checks++;
      if (!OutValid || OutData != held) begin
        errors++;
        $display("FAIL hold: got valid=%0b data=0x%0h expected valid=1 data=0x%0h", OutValid, OutData, held);
      end
    end
    if (OutValid && OutReady) begin
      checks++;
      out_cnt++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got 0x%0h expected no output", OutData);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        if (OutData != e) begin
          errors++;
          $display("FAIL out_data: got 0x%0h expected 0x%0h", OutData, e);
        end
      end
    end
    stall_prev = OutValid && !OutReady;
    held       = OutData;
    rst_prev   = Reset;
  end

  // Builds the cipher stream and pushes expected plaintext.
  task automatic prep_msg(input logic [6:0] seed, input logic [6:0] taps,
                          input int pre, input int len, input int pay,
                          input bit garb, output int nexp);
    logic [6:0] k;
    logic [7:0] p;
    int eff;
    cbuf.delete();
    nexp = 0;
    k = seed;
    eff = (pre == 0) ? 1 : pre;
    for (int i = 0; i < len; i++) begin
      if (i < eff) begin
        p = 8'h20;
        if (garb && i > 0 && ($urandom % 3) == 0) p = 8'($urandom);
      end else begin
        p = (pay != 0) ? 8'(pay) : 8'($urandom);
        expq.push_back(p);
        nexp++;
      end
      cbuf.push_back(p ^ {1'b0, k});
      k = step(k, taps);
    end
  endtask

  task automatic start_msg(input logic [6:0] taps, input int pre, input int len);
    Start = 1'b1; Taps = taps; PreLen = 6'(pre); MsgLen = 8'(len);
    @(posedge Clk); #1;
    Start = 1'b0; Taps = 7'($urandom); PreLen = 6'($urandom); MsgLen = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    InValid = 1'b0;
    repeat (gap) begin @(posedge Clk); #1; end
    InValid = 1'b1; InData = b; ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge Clk);
      if (InReady) begin ok = 1; break; end
    end
    @(posedge Clk); #1;
    InValid = 1'b0; InData = 8'($urandom);
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int d0);
    bit ok;
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge Clk); #2;
      if (done_cnt > d0) begin ok = 1; break; end
    end
    check("done_pulse", int'(ok), 1);
  endtask

  task automatic run_msg(input logic [6:0] seed, input logic [6:0] taps,
                         input int pre, input int len, input int pay,
                         input bit garb, input int maxgap);
    int d0, o0, nexp;
    d0 = done_cnt; o0 = out_cnt;
    prep_msg(seed, taps, pre, len, pay, garb, nexp);
    start_msg(taps, pre, len);
    for (int i = 0; i < len; i++)
      send_byte(cbuf[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    wait_done(d0);
    check("out_count", out_cnt - o0, nexp);
    check("queue_empty", expq.size(), 0);
    check("taperr", int'(TapErr), 0);
    @(posedge Clk); #1;
  endtask

  initial begin
    int d0, nexp;
    Reset = 1'b1; Start = 1'b0; Taps = '0; PreLen = '0; MsgLen = '0;
    InValid = 1'b0; InData = '0; OutReady = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_inready", int'(InReady), 0);
    check("rst_outvalid", int'(OutValid), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_taperr", int'(TapErr), 0);
    check("rst_outdata", int'(OutData), 0);
    @(posedge Clk); #1; Reset = 1'b0;

    // Basic stream 0x21 0x22 0x45 -> 0x41, one cycle after the last accept.
    or_mode = 0; OutReady = 1'b1;
    d0 = done_cnt;
    prep_msg(7'h01, 7'h60, 2, 3, 8'h41, 0, nexp);
    check("cipher_b2", int'(cbuf[2]), 8'h45);
    start_msg(7'h60, 2, 3);
    for (int i = 0; i < 3; i++) send_byte(cbuf[i], 0);
    @(negedge Clk);
    check("lat_valid", int'(OutValid), 1);
    check("lat_data", int'(OutData), 8'h41);
    wait_done(d0);
    check("basic_taperr", int'(TapErr), 0);
    @(posedge Clk); #1;

    // Same stream with a 5-cycle downstream stall.
    or_mode = 1; OutReady = 1'b0;
    d0 = done_cnt;
    prep_msg(7'h01, 7'h60, 2, 3, 8'h41, 0, nexp);
    start_msg(7'h60, 2, 3);
    for (int i = 0; i < 3; i++) send_byte(cbuf[i], 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      check("stall_valid", int'(OutValid), 1);
      check("stall_data", int'(OutData), 8'h41);
      check("stall_inready", int'(InReady), 0);
      check("stall_done", int'(Done), 0);
    end
    or_mode = 0; OutReady = 1'b1;
    wait_done(d0);
    check("stall_queue", expq.size(), 0);
    @(posedge Clk); #1;

    // MsgLen == 0: Done two cycles after Start, nothing accepted.
    d0 = done_cnt;
    start_msg(7'h60, 2, 0);
    @(negedge Clk);
    check("len0_inready", int'(InReady), 0);
    check("len0_done_early", int'(Done), 0);
    @(negedge Clk);
    check("len0_done", int'(Done), 1);
    check("len0_inready2", int'(InReady), 0);
    @(posedge Clk); #1;

    // Whole message is preamble.
    run_msg(7'h33, 7'h48, 5, 3, 0, 0, 1);

    // Reset mid-RUN with a held output byte.
    or_mode = 1; OutReady = 1'b0;
    prep_msg(7'h5A, 7'h72, 2, 6, 0, 0, nexp);
    start_msg(7'h72, 2, 6);
    for (int i = 0; i < 3; i++) send_byte(cbuf[i], 0);
    @(negedge Clk);
    check("mid_valid", int'(OutValid), 1);
    check("mid_busy", int'(Busy), 1);
    @(posedge Clk); #1; Reset = 1'b1;
    @(posedge Clk); #1; Reset = 1'b0;
    @(negedge Clk);
    check("rst_mid_valid", int'(OutValid), 0);
    check("rst_mid_busy", int'(Busy), 0);
    check("rst_mid_inready", int'(InReady), 0);
    expq.delete();
    @(posedge Clk); #1;

    // Reset wins over Start.
    Reset = 1'b1; Start = 1'b1; MsgLen = 8'd5; PreLen = 6'd1;
    @(posedge Clk); #1; Reset = 1'b0; Start = 1'b0;
    @(negedge Clk);
    check("rst_start_busy", int'(Busy), 0);
    @(posedge Clk); #1;

    or_mode = 0; OutReady = 1'b1;
    run_msg(7'h01, 7'h60, 2, 3, 8'h41, 0, 0);
    run_msg(7'h2C, 7'h69, 0, 6, 0, 0, 0);   // PreLen 0 acts as 1
    run_msg(7'h11, 7'h7B, 3, 1, 0, 0, 0);   // MsgLen 1: seed byte only

    or_mode = 2;
    for (int m = 0; m < 40; m++)
      run_msg(7'($urandom), 7'($urandom), $urandom_range(0, 8),
              $urandom_range(0, 20), 0, 1'($urandom % 2), $urandom_range(0, 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lfsr_decrypt_engine.md
Name: lfsr_decrypt_engine

Overview:
Hardware LFSR decryptor: the decrypt-side counterpart of the space-preamble LFSR encryption program whose tap, seed and preamble constants are preloaded into the register file.
- Consumes an encrypted byte stream through a valid/ready handshake.
- Recovers the LFSR start state from the first preamble byte, which is always a space (0x20).
- Strips the preamble and emits decrypted plaintext bytes downstream through a valid/ready handshake.
- Sits between the DataMem read sequencer and the result writer.

Parameters:
W, 8, data byte width (fixed at 8)
L, 7, LFSR state width; keystream byte = {1'b0, state}
CW, 8, message length counter width

Ports:
Clk       input   1     clock, rising edge
Reset     input   1     synchronous, active-high reset
Start     input   1     one-cycle pulse in IDLE; latches Taps, PreLen, MsgLen
Taps      input   L     LFSR feedback tap mask
PreLen    input   6     number of leading space bytes; a value of 0 is treated as 1
MsgLen    input   CW    total encrypted bytes including preamble
InValid   input   1     encrypted byte available
InReady   output  1     engine accepts InData this cycle
InData    input   W     encrypted byte
OutValid  output  1     plaintext byte valid
OutReady  input   1     downstream accepts OutData
OutData   output  W     plaintext byte
Busy      output  1     high in SEED or RUN
Done      output  1     one-cycle pulse when the message completes
TapErr    output  1     sticky tap-search failure (tied 0 without the optional feature)

Behaviour:
- Reset: state IDLE. InReady, OutValid, Busy, Done and TapErr are 0. OutData, LFSR state and counters are 0.
- Reset mid-message aborts the message. Any held output byte is discarded. Reset wins over Start.
- LFSR advance: next = {state[L-2:0], ^(state & Taps)}.
- Decryption: plain = cipher ^ {1'b0, state}.
- A byte is accepted when InValid && InReady. Idx counts accepted bytes from 0.
- FSM:
  - IDLE: Start latches inputs and clears Idx.
    - MsgLen==0: go to DONE; no bytes are accepted.
    - Otherwise: go to SEED.
  - SEED: InReady=1. On accept:
    - state <= next(cipher[L-1:0] ^ 7'h20).
    - Byte 0 is never emitted.
    - Idx becomes 1. If MsgLen==1 go to DONE, else go to RUN.
  - RUN: on each accept, plain is computed with the current state, then state advances.
    - Idx < PreLen: byte dropped (preamble). The plaintext value is not checked.
    - Idx ≥ PreLen: plain is loaded into OutData and OutValid is set.
    - The accept with Idx==MsgLen-1 goes to DONE.
  - DONE: waits until OutValid==0, pulses Done for one cycle, then returns to IDLE.
- Output buffer: a single entry.
  - OutValid clears on OutValid && OutReady unless it is reloaded in the same cycle.
  - In RUN, InReady = !OutValid || OutReady. Simultaneous drain and load is allowed: full throughput of 1 byte/cycle.
  - Preamble bytes are accepted even when the output is stalled.
- Latency: the plaintext appears on OutValid the cycle after its input is accepted.
- PreLen ≥ MsgLen: the whole message is preamble, no output is produced, and Done still pulses.
- OutData and OutValid stay stable while OutValid && !OutReady.
- Start outside IDLE is ignored. Taps, PreLen and MsgLen are sampled only at Start.
- Busy = (state==SEED || state==RUN).

Optional Feature:
Macro: LFSR_TAP_SEARCH_EN.
- Defined:
  - Taps input is ignored.
  - Fixed candidate table: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
  - Nine shadow LFSRs are seeded in SEED, each advancing with its own taps. A 9-bit alive mask starts as all ones.
  - On each preamble byte in RUN, each candidate whose plain ≠ 0x20 is cleared from the mask.
  - At the first non-preamble byte, the lowest-index alive candidate is used for the rest of the message.
  - If the mask is zero: TapErr is set (sticky until the next Start or Reset). Bytes are still decrypted with candidate 0.
- Undefined: Taps port is used, there are no shadow LFSRs, and TapErr is tied 0.

Test Plan:
- Taps=0x60, PreLen=2, MsgLen=3, input 0x21, 0x22, 0x45, OutReady=1 -> one output 0x41 one cycle after the third accept; Done pulses; TapErr=0.
- Same stream with OutReady held 0 for 5 cycles after the first output -> OutData is held at 0x41, InReady=0, no byte lost; Done pulses after OutReady rises.
- MsgLen=0, Start -> no InReady; Done pulses two cycles after Start.
- PreLen=5, MsgLen=3 -> three bytes accepted, OutValid never rises, Done pulses.
- Reset asserted mid-RUN with OutValid=1 -> next cycle OutValid=0, IDLE, Busy=0; a new Start decrypts correctly.
- With LFSR_TAP_SEARCH_EN, seed 0x01, taps 0x48, PreLen=8 -> correct plaintext, TapErr=0. With garbage preamble bytes -> TapErr=1.
